// File: rtl/joy_db15_responder.sv
// ============================================================================
// joy_db15_responder : device end of the DB15 serial joystick link
// Optional macro JOY_RESP_TIMEOUT_EN enables the SHIFT idle-abort counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module joy_db15_responder #(
  parameter int unsigned NBITS       = 16,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             joy_load_i,
  input  logic             joy_clk_i,
  input  logic [NBITS-1:0] joystick1,
  input  logic [NBITS-1:0] joystick2,
  output logic             joy_data_o,
  output logic             frame_done,
  output logic             overrun,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned    FBITS    = 2 * NBITS;
  localparam int unsigned    CW       = (FBITS > 1) ? $clog2(FBITS) : 1;
  localparam int unsigned    FCW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(FBITS - 1);
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILT_LEN - 1);
  localparam int             PIN_LOAD = 0;
  localparam int             PIN_CLK  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       filt_q, filt_d;
  logic [FCW-1:0]   fcnt_q [2];
  logic [FCW-1:0]   fcnt_d [2];

  state_t           state_q, state_d;
  logic [FBITS-1:0] sr_q, sr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             joy_data_q, joy_data_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic             load_low;
  logic             clk_rise;

`ifdef JOY_RESP_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYC);
  logic [15:0]      idle_cnt_q, idle_cnt_d;
`else
  logic             unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Glitch filter: the accepted level moves only after FILT_LEN straight cycles at the new level.
  always_comb begin
    sync1_d = {joy_clk_i, joy_load_i};
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign load_low = ~filt_d[PIN_LOAD];
  assign clk_rise = filt_d[PIN_CLK] & ~filt_q[PIN_CLK];

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    joy_data_d   = 1'b1;
`ifdef JOY_RESP_TIMEOUT_EN
    idle_cnt_d   = '0;
`endif
    if (state_q == ST_LOAD || state_q == ST_SHIFT) begin
      joy_data_d = sr_q[0];
    end

    // Load low wins over every state and over a coincident clock rise.
    if (load_low) begin
      state_d   = ST_LOAD;
      sr_d      = ~{joystick2, joystick1};
      bit_cnt_d = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_LOAD: begin
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
`ifdef JOY_RESP_TIMEOUT_EN
          if (!clk_rise) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
            if (idle_cnt_d == TIMEOUT_W) begin
              state_d    = ST_IDLE;
              joy_data_d = 1'b1;
            end
          end
`endif
          if (clk_rise) begin
            if (bit_cnt_q == LAST_BIT) begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 8'd1;
              state_d      = ST_DONE;
            end else begin
              sr_d      = {1'b1, sr_q[FBITS-1:1]};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (clk_rise) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q      <= 2'b11;
      sync2_q      <= 2'b11;
      filt_q       <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        fcnt_q[i] <= '0;
      end
      state_q      <= ST_IDLE;
      sr_q         <= '1;
      bit_cnt_q    <= '0;
      joy_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef JOY_RESP_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      filt_q       <= filt_d;
      for (int i = 0; i < 2; i++) begin
        fcnt_q[i] <= fcnt_d[i];
      end
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      joy_data_q   <= joy_data_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef JOY_RESP_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
`endif
    end
  end

  assign joy_data_o = joy_data_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_joy_db15_responder.sv
// ============================================================================
// tb_joy_db15_responder : host-side bench with expected-value scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_joy_db15_responder;

  localparam int K_DATA  = 0;
  localparam int K_FCNT  = 1;
  localparam int K_OVR   = 2;
  localparam int K_DONES = 3;
  localparam int PHASE   = 10;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_load_i = 1'b1;
  logic        joy_clk_i = 1'b0;
  logic [15:0] joystick1 = 16'h0000;
  logic [15:0] joystick2 = 16'h0000;
  logic        joy_data_o;
  logic        frame_done;
  logic        overrun;
  logic [7:0]  frame_cnt;

  item_t       sb_q[$];
  logic        sample = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          dut_dones = 0;
  logic        done_prev = 1'b0;
  logic [31:0] frame;

  always #10 clk = ~clk;

  joy_db15_responder #(
    .NBITS(16),
    .FILT_LEN(4),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .joy_load_i(joy_load_i),
    .joy_clk_i(joy_clk_i),
    .joystick1(joystick1),
    .joystick2(joystick2),
    .joy_data_o(joy_data_o),
    .frame_done(frame_done),
    .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  // Monitor: counts frame_done pulses and checks queued expectations on sample strobes.
  always @(negedge clk) begin
    item_t       it;
    logic [31:0] act;
    if (frame_done) begin
      dut_dones++;
      checks++;
      if (done_prev) begin
        failures++;
        $display("FAIL frame_done_width actual=2+cycles required=1");
      end
    end
    done_prev = frame_done;
    if (sample) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
        it = sb_q.pop_front();
        case (it.kind)
          K_DATA:  act = {31'd0, joy_data_o};
          K_FCNT:  act = {24'd0, frame_cnt};
          K_OVR:   act = {31'd0, overrun};
          default: act = dut_dones;
        endcase
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s actual=%0h required=%0h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input int kind, input logic [31:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb_q.push_back(it);
    sample = 1'b1;
    wait_cyc(1);
    sample = 1'b0;
  endtask

  task automatic host_load();
    joy_load_i = 1'b0;
    wait_cyc(PHASE);
    joy_load_i = 1'b1;
    wait_cyc(PHASE);
  endtask

  task automatic host_clk();
    joy_clk_i = 1'b1;
    wait_cyc(PHASE);
    joy_clk_i = 1'b0;
    wait_cyc(PHASE);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset held while host pins toggle.
    reset_n   = 1'b0;
    joystick1 = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      joy_load_i = ~joy_load_i;
      joy_clk_i  = ~joy_clk_i;
      wait_cyc(3);
    end
    check(K_DATA, 32'd1, "rst_data");
    check(K_FCNT, 32'd0, "rst_fcnt");
    check(K_OVR, 32'd0, "rst_ovr");
    check(K_DONES, 32'd0, "rst_dones");
    joy_load_i = 1'b1;
    joy_clk_i  = 1'b0;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(12);

    // Glitch rejection then accepted 5-cycle load pulse.
    joystick1 = 16'h0001;
    joystick2 = 16'h0000;
    joy_load_i = 1'b0;
    wait_cyc(2);
    joy_load_i = 1'b1;
    wait_cyc(12);
    check(K_DATA, 32'd1, "glitch_data");
    joy_load_i = 1'b0;
    wait_cyc(5);
    joy_load_i = 1'b1;
    wait_cyc(12);
    check(K_DATA, 32'd0, "pulse5_data");

    // Full frame order.
    joystick1 = 16'h0005;
    joystick2 = 16'h8000;
    frame = ~{16'h8000, 16'h0005};
    host_load();
    check(K_DATA, {31'd0, frame[0]}, "f1_bit0");
    for (int k = 1; k < 32; k++) begin
      host_clk();
      check(K_DATA, {31'd0, frame[k]}, $sformatf("f1_bit%0d", k));
    end
    host_clk();
    check(K_FCNT, 32'd1, "f1_fcnt");
    check(K_DONES, 32'd1, "f1_dones");
    check(K_DATA, 32'd1, "f1_done_data");
    check(K_OVR, 32'd0, "f1_no_ovr");

    // Overrun on the 33rd rise, cleared by the next load.
    host_clk();
    check(K_OVR, 32'd1, "ovr_set");
    check(K_DATA, 32'd1, "ovr_data");
    check(K_DONES, 32'd1, "ovr_dones");
    host_load();
    check(K_OVR, 32'd0, "ovr_clear");

    // Mid-frame reload coincident with a clock rise.
    for (int k = 1; k <= 10; k++) begin
      host_clk();
    end
    check(K_DATA, {31'd0, frame[10]}, "pre_reload_bit10");
    joystick1  = 16'h3C0F;
    joystick2  = 16'hF00D;
    frame      = ~{16'hF00D, 16'h3C0F};
    joy_load_i = 1'b0;
    joy_clk_i  = 1'b1;
    wait_cyc(PHASE);
    joy_load_i = 1'b1;
    joy_clk_i  = 1'b0;
    wait_cyc(PHASE);
    joystick1 = 16'hFFFF;
    joystick2 = 16'h0000;
    check(K_DATA, {31'd0, frame[0]}, "f2_bit0");
    for (int k = 1; k < 32; k++) begin
      host_clk();
      check(K_DATA, {31'd0, frame[k]}, $sformatf("f2_bit%0d", k));
    end
    check(K_FCNT, 32'd1, "f2_fcnt_before");
    check(K_DONES, 32'd1, "f2_dones_before");
    host_clk();
    check(K_FCNT, 32'd2, "f2_fcnt");
    check(K_DONES, 32'd2, "f2_dones");

    // Idle in SHIFT after three rises.
    frame = ~{16'h0000, 16'hFFFF};
    host_load();
    for (int k = 1; k <= 3; k++) begin
      host_clk();
    end
    check(K_DATA, {31'd0, frame[3]}, "idle_bit3");
    wait_cyc(120);
`ifdef JOY_RESP_TIMEOUT_EN
    check(K_DATA, 32'd1, "timeout_data");
    check(K_FCNT, 32'd2, "timeout_fcnt");
    host_clk();
    check(K_DATA, 32'd1, "timeout_idle_data");
    check(K_DONES, 32'd2, "timeout_dones");
`else
    check(K_DATA, {31'd0, frame[3]}, "no_timeout_data");
    check(K_FCNT, 32'd2, "no_timeout_fcnt");
`endif

    // Reset mid-frame.
    joystick1 = 16'h0001;
    host_load();
    host_clk();
    host_clk();
    check(K_DATA, 32'd1, "pre_rst_bit2");
    reset_n = 1'b0;
    wait_cyc(1);
    check(K_DATA, 32'd1, "midrst_data");
    check(K_FCNT, 32'd0, "midrst_fcnt");
    check(K_OVR, 32'd0, "midrst_ovr");
    reset_n = 1'b1;
    wait_cyc(4);
    check(K_DONES, 32'd2, "final_dones");

    wait_cyc(2);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
